// File: rtl/closest_hit_dispatch_pkg.sv
// Shared types and IEEE float field helpers for the closest-hit dispatcher.
// Helpers take the format width at call time so one package serves SIZE=32 and SIZE=64.
package closest_hit_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2,
        ST_MISS    = 2'd3
    } state_t;

    localparam int MAX_W = 64;

    function automatic logic fp_sign(input logic [MAX_W-1:0] f, input int size);
        return f[size-1];
    endfunction

    function automatic logic [MAX_W-1:0] fp_exp(input logic [MAX_W-1:0] f, input int size,
                                                input int exp_bits);
        return (f >> (size - 1 - exp_bits)) & ((64'd1 << exp_bits) - 64'd1);
    endfunction

    function automatic logic [MAX_W-1:0] fp_mag(input logic [MAX_W-1:0] f, input int size);
        return f & ((64'd1 << (size - 1)) - 64'd1);
    endfunction

    // Rejects negatives, +/-0, infinities and NaNs; subnormals are valid hits.
    function automatic logic float_is_pos_finite(input logic [MAX_W-1:0] f, input int size,
                                                 input int exp_bits);
        logic [MAX_W-1:0] exp_ones;
        exp_ones = (64'd1 << exp_bits) - 64'd1;
        return !fp_sign(f, size) && (fp_mag(f, size) != '0) &&
               (fp_exp(f, size, exp_bits) != exp_ones);
    endfunction

endpackage

// File: rtl/closest_hit_dispatch_if.sv
// Stream bundle between the candidate producer, the dispatcher and the hit-point stage.
// master is the dispatcher side; slave is its environment.
interface closest_hit_dispatch_if #(
    parameter int SIZE  = 32,
    parameter int IDX_W = 8
);
    logic [6*SIZE-1:0] ray_in_tdata;
    logic              ray_in_tvalid;
    logic              ray_in_tready;

    logic [6*SIZE-1:0] cand_tdata;
    logic [SIZE-1:0]   cand_t;
    logic              cand_is_cylinder;
    logic              cand_tlast;
    logic              cand_tvalid;
    logic              cand_tready;

    logic [6*SIZE-1:0] obj_axis_tdata;
    logic              obj_axis_is_cylinder;
    logic              obj_axis_tvalid;
    logic              obj_axis_tready;

    logic [SIZE-1:0]   t_axis_tdata;
    logic              t_axis_tvalid;
    logic              t_axis_tready;

    logic [6*SIZE-1:0] ray_axis_tdata;
    logic              ray_axis_tvalid;
    logic              ray_axis_tready;

    logic [IDX_W-1:0]  hit_idx;
    logic              miss_tvalid;
    logic              miss_tready;

    modport master (
        input  ray_in_tdata, ray_in_tvalid,
        output ray_in_tready,
        input  cand_tdata, cand_t, cand_is_cylinder, cand_tlast, cand_tvalid,
        output cand_tready,
        output obj_axis_tdata, obj_axis_is_cylinder, obj_axis_tvalid,
        input  obj_axis_tready,
        output t_axis_tdata, t_axis_tvalid,
        input  t_axis_tready,
        output ray_axis_tdata, ray_axis_tvalid,
        input  ray_axis_tready,
        output hit_idx, miss_tvalid,
        input  miss_tready
    );

    modport slave (
        output ray_in_tdata, ray_in_tvalid,
        input  ray_in_tready,
        output cand_tdata, cand_t, cand_is_cylinder, cand_tlast, cand_tvalid,
        input  cand_tready,
        input  obj_axis_tdata, obj_axis_is_cylinder, obj_axis_tvalid,
        output obj_axis_tready,
        input  t_axis_tdata, t_axis_tvalid,
        output t_axis_tready,
        input  ray_axis_tdata, ray_axis_tvalid,
        output ray_axis_tready,
        input  hit_idx, miss_tvalid,
        output miss_tready
    );
endinterface

// File: rtl/closest_hit_dispatch_float_pos_lt.sv
// Positive-float validity check and ordering compare for nearest-hit selection.
// The stored best is always a valid positive float, so only its magnitude is needed.
module float_pos_lt
    import closest_hit_dispatch_pkg::*;
#(
    parameter int SIZE     = 32,
    parameter int EXP_BITS = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-2:0] b_mag,
    output logic            a_valid,
    output logic            a_lt_b
);
    logic [MAX_W-1:0] a_ext;

    assign a_ext   = MAX_W'(a);
    assign a_valid = float_is_pos_finite(a_ext, SIZE, EXP_BITS);
    // Positive IEEE floats order the same as their raw bit patterns.
    assign a_lt_b  = a[SIZE-2:0] < b_mag;
endmodule

// File: rtl/closest_hit_dispatch.sv
// Collects per-object candidates for one ray, keeps the nearest positive t and
// dispatches ray/t/object together, or reports a miss when nothing was hit.
module closest_hit_dispatch
    import closest_hit_dispatch_pkg::*;
#(
    parameter int SIZE     = 32,
    parameter int EXP_BITS = 8,
    parameter int IDX_W    = 8
) (
    input  logic aclk,
    input  logic areset,
    closest_hit_dispatch_if.master bus
);
    state_t state, state_nxt;

    logic [6*SIZE-1:0] ray_q;
    logic [6*SIZE-1:0] obj_q;
    logic [SIZE-1:0]   best_t;
    logic              best_cyl;
    logic              best_valid;
    logic [IDX_W-1:0]  idx_cnt;
    logic [IDX_W-1:0]  best_idx;

    logic cand_ok, cand_lt, cand_fire, take, out_fire;

    float_pos_lt #(
        .SIZE     (SIZE),
        .EXP_BITS (EXP_BITS)
    ) u_cmp (
        .a       (bus.cand_t),
        .b_mag   (best_t[SIZE-2:0]),
        .a_valid (cand_ok),
        .a_lt_b  (cand_lt)
    );

    assign cand_fire = (state == ST_COLLECT) && bus.cand_tvalid;
    // Strict less-than keeps the earliest candidate on ties.
    assign take      = cand_fire && cand_ok && (!best_valid || cand_lt);
    assign out_fire  = bus.obj_axis_tready && bus.t_axis_tready && bus.ray_axis_tready;

    always_ff @(posedge aclk) begin
        if (areset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (bus.ray_in_tvalid) state_nxt = ST_COLLECT;
            ST_COLLECT: if (cand_fire && bus.cand_tlast)
                            state_nxt = (best_valid || take) ? ST_EMIT : ST_MISS;
            ST_EMIT:    if (out_fire) state_nxt = ST_IDLE;
            ST_MISS:    if (bus.miss_tready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.ray_in_tready   = 1'b0;
        bus.cand_tready     = 1'b0;
        bus.obj_axis_tvalid = 1'b0;
        bus.t_axis_tvalid   = 1'b0;
        bus.ray_axis_tvalid = 1'b0;
        bus.miss_tvalid     = 1'b0;
        case (state)
            ST_IDLE:    bus.ray_in_tready = !areset;
            ST_COLLECT: bus.cand_tready   = 1'b1;
            ST_EMIT: begin
                bus.obj_axis_tvalid = 1'b1;
                bus.t_axis_tvalid   = 1'b1;
                bus.ray_axis_tvalid = 1'b1;
            end
            ST_MISS:    bus.miss_tvalid   = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ray_q      <= '0;
            obj_q      <= '0;
            best_t     <= '0;
            best_cyl   <= 1'b0;
            best_valid <= 1'b0;
            idx_cnt    <= '0;
            best_idx   <= '0;
        end else begin
            if (state == ST_IDLE && bus.ray_in_tvalid) begin
                ray_q      <= bus.ray_in_tdata;
                best_valid <= 1'b0;
                idx_cnt    <= '0;
            end
            if (cand_fire) begin
                if (take) begin
                    obj_q      <= bus.cand_tdata;
                    best_cyl   <= bus.cand_is_cylinder;
                    best_t     <= bus.cand_t;
                    best_idx   <= idx_cnt;
                    best_valid <= 1'b1;
                end
                if (!(&idx_cnt)) idx_cnt <= idx_cnt + 1'b1;
            end
        end
    end

    assign bus.obj_axis_tdata       = obj_q;
    assign bus.obj_axis_is_cylinder = best_cyl;
    assign bus.t_axis_tdata         = best_t;
    assign bus.ray_axis_tdata       = ray_q;
    assign bus.hit_idx              = best_idx;
endmodule

// File: tb/tb_closest_hit_dispatch.sv
// Directed checks for closest_hit_dispatch: nearest-hit choice, misses, ties,
// backpressure, single-candidate rays and reset mid-collect.
module tb_closest_hit_dispatch;
    logic aclk = 1'b0;
    logic areset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 aclk = ~aclk;

    closest_hit_dispatch_if #(.SIZE(32), .IDX_W(8)) bus ();

    closest_hit_dispatch #(.SIZE(32), .EXP_BITS(8), .IDX_W(8)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_ray(input logic [31:0] tag);
        int cyc = 0;
        bus.ray_in_tdata  = {6{tag}};
        bus.ray_in_tvalid = 1'b1;
        while (!bus.ray_in_tready && cyc < 20) begin tick(); cyc++; end
        n_checks++;
        if (bus.ray_in_tready !== 1'b1) begin
            n_errors++;
            $display("FAIL ray_accept_timeout: ray_in_tready=%b required 1", bus.ray_in_tready);
        end
        tick();
        bus.ray_in_tvalid = 1'b0;
    endtask

    task automatic send_cand(input logic [31:0] t, input logic [31:0] tag, input logic cyl,
                             input logic last);
        int cyc = 0;
        bus.cand_t           = t;
        bus.cand_tdata       = {6{tag}};
        bus.cand_is_cylinder = cyl;
        bus.cand_tlast       = last;
        bus.cand_tvalid      = 1'b1;
        while (!bus.cand_tready && cyc < 20) begin tick(); cyc++; end
        n_checks++;
        if (bus.cand_tready !== 1'b1) begin
            n_errors++;
            $display("FAIL cand_accept_timeout: cand_tready=%b required 1", bus.cand_tready);
        end
        tick();
        bus.cand_tvalid = 1'b0;
        bus.cand_tlast  = 1'b0;
    endtask

    task automatic drain_emit(input string name);
        bus.obj_axis_tready = 1'b1;
        bus.t_axis_tready   = 1'b1;
        bus.ray_axis_tready = 1'b1;
        tick();
        n_checks++;
        if (bus.obj_axis_tvalid !== 1'b0 || bus.ray_in_tready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_drain: obj_tvalid=%b ray_in_tready=%b required 0/1",
                     name, bus.obj_axis_tvalid, bus.ray_in_tready);
        end
        bus.obj_axis_tready = 1'b0;
        bus.t_axis_tready   = 1'b0;
        bus.ray_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.ray_in_tready, bus.cand_tready, bus.obj_axis_tvalid, bus.t_axis_tvalid,
             bus.ray_axis_tvalid, bus.miss_tvalid} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_handshakes: rdy/valid=%b required 000000",
                     {bus.ray_in_tready, bus.cand_tready, bus.obj_axis_tvalid,
                      bus.t_axis_tvalid, bus.ray_axis_tvalid, bus.miss_tvalid});
        end
        n_checks++;
        if (bus.hit_idx !== 8'd0 || bus.t_axis_tdata !== 32'd0 || bus.ray_axis_tdata !== '0) begin
            n_errors++;
            $display("FAIL reset_data: hit_idx=%0d t=%h required 0/0", bus.hit_idx, bus.t_axis_tdata);
        end
        areset = 1'b0;
        tick();
        n_checks++;
        if (bus.ray_in_tready !== 1'b1 || bus.cand_tready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: ray_in_tready=%b cand_tready=%b required 1/0",
                     bus.ray_in_tready, bus.cand_tready);
        end
    endtask

    task automatic test_nearest();
        send_ray(32'h1111_0001);
        send_cand(32'h40A00000, 32'hA000_0000, 1'b0, 1'b0);
        send_cand(32'h40000000, 32'hA000_0001, 1'b1, 1'b0);
        send_cand(32'h40400000, 32'hA000_0002, 1'b0, 1'b1);
        n_checks++;
        if ({bus.obj_axis_tvalid, bus.t_axis_tvalid, bus.ray_axis_tvalid, bus.miss_tvalid} !== 4'b1110) begin
            n_errors++;
            $display("FAIL nearest_valids: obj/t/ray/miss=%b required 1110",
                     {bus.obj_axis_tvalid, bus.t_axis_tvalid, bus.ray_axis_tvalid, bus.miss_tvalid});
        end
        n_checks++;
        if (bus.t_axis_tdata !== 32'h40000000 || bus.hit_idx !== 8'd1) begin
            n_errors++;
            $display("FAIL nearest_t_idx: t=%h idx=%0d required 40000000/1", bus.t_axis_tdata, bus.hit_idx);
        end
        n_checks++;
        if (bus.obj_axis_tdata !== {6{32'hA000_0001}} || bus.obj_axis_is_cylinder !== 1'b1) begin
            n_errors++;
            $display("FAIL nearest_obj: obj[31:0]=%h cyl=%b required a0000001/1",
                     bus.obj_axis_tdata[31:0], bus.obj_axis_is_cylinder);
        end
        n_checks++;
        if (bus.ray_axis_tdata !== {6{32'h1111_0001}}) begin
            n_errors++;
            $display("FAIL nearest_ray: ray[31:0]=%h required 11110001", bus.ray_axis_tdata[31:0]);
        end
        drain_emit("nearest");
    endtask

    task automatic test_miss();
        send_ray(32'h2222_0002);
        send_cand(32'hBF800000, 32'hB000_0000, 1'b0, 1'b0);
        send_cand(32'h00000000, 32'hB000_0001, 1'b0, 1'b0);
        send_cand(32'h7FC00000, 32'hB000_0002, 1'b0, 1'b1);
        tick();
        n_checks++;
        if ({bus.obj_axis_tvalid, bus.t_axis_tvalid, bus.ray_axis_tvalid, bus.miss_tvalid} !== 4'b0001) begin
            n_errors++;
            $display("FAIL miss_valids: obj/t/ray/miss=%b required 0001",
                     {bus.obj_axis_tvalid, bus.t_axis_tvalid, bus.ray_axis_tvalid, bus.miss_tvalid});
        end
        bus.miss_tready = 1'b1;
        tick();
        bus.miss_tready = 1'b0;
        n_checks++;
        if (bus.miss_tvalid !== 1'b0 || bus.ray_in_tready !== 1'b1 || bus.obj_axis_tvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL miss_release: miss=%b ray_in_tready=%b obj_tvalid=%b required 0/1/0",
                     bus.miss_tvalid, bus.ray_in_tready, bus.obj_axis_tvalid);
        end
    endtask

    task automatic test_tie();
        send_ray(32'h3333_0003);
        send_cand(32'h40800000, 32'hC000_0000, 1'b0, 1'b0);
        send_cand(32'h40800000, 32'hC000_0001, 1'b1, 1'b1);
        n_checks++;
        if (bus.hit_idx !== 8'd0 || bus.obj_axis_tdata !== {6{32'hC000_0000}} ||
            bus.obj_axis_is_cylinder !== 1'b0) begin
            n_errors++;
            $display("FAIL tie_first_wins: idx=%0d obj[31:0]=%h cyl=%b required 0/c0000000/0",
                     bus.hit_idx, bus.obj_axis_tdata[31:0], bus.obj_axis_is_cylinder);
        end
        drain_emit("tie");
    endtask

    task automatic test_inf_subnormal();
        send_ray(32'h4444_0004);
        send_cand(32'h7F800000, 32'hD000_0000, 1'b0, 1'b0);
        send_cand(32'h41000000, 32'hD000_0001, 1'b0, 1'b0);
        send_cand(32'h00000001, 32'hD000_0002, 1'b1, 1'b1);
        n_checks++;
        if (bus.t_axis_tdata !== 32'h00000001 || bus.hit_idx !== 8'd2) begin
            n_errors++;
            $display("FAIL inf_subnormal: t=%h idx=%0d required 00000001/2", bus.t_axis_tdata, bus.hit_idx);
        end
        drain_emit("inf_subnormal");
    endtask

    task automatic test_backpressure();
        send_ray(32'h5555_0005);
        send_cand(32'h41100000, 32'hE000_0000, 1'b0, 1'b0);
        send_cand(32'h3FC00000, 32'hE000_0001, 1'b1, 1'b1);
        bus.t_axis_tready   = 1'b1;
        bus.ray_axis_tready = 1'b1;
        bus.obj_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({bus.obj_axis_tvalid, bus.t_axis_tvalid, bus.ray_axis_tvalid} !== 3'b111 ||
                bus.t_axis_tdata !== 32'h3FC00000 || bus.obj_axis_tdata !== {6{32'hE000_0001}} ||
                bus.hit_idx !== 8'd1) begin
                n_errors++;
                $display("FAIL backpressure_hold[%0d]: valids=%b t=%h idx=%0d required 111/3fc00000/1",
                         i, {bus.obj_axis_tvalid, bus.t_axis_tvalid, bus.ray_axis_tvalid},
                         bus.t_axis_tdata, bus.hit_idx);
            end
        end
        bus.obj_axis_tready = 1'b1;
        tick();
        n_checks++;
        if (bus.obj_axis_tvalid !== 1'b0 || bus.t_axis_tvalid !== 1'b0 || bus.ray_in_tready !== 1'b1) begin
            n_errors++;
            $display("FAIL backpressure_release: obj/t valid=%b%b ray_in_tready=%b required 00/1",
                     bus.obj_axis_tvalid, bus.t_axis_tvalid, bus.ray_in_tready);
        end
        bus.obj_axis_tready = 1'b0;
        bus.t_axis_tready   = 1'b0;
        bus.ray_axis_tready = 1'b0;
    endtask

    task automatic test_single();
        send_ray(32'h6666_0006);
        send_cand(32'h3F800000, 32'hF000_0000, 1'b1, 1'b1);
        n_checks++;
        if (bus.t_axis_tvalid !== 1'b1 || bus.t_axis_tdata !== 32'h3F800000 || bus.hit_idx !== 8'd0) begin
            n_errors++;
            $display("FAIL single_cand: tvalid=%b t=%h idx=%0d required 1/3f800000/0",
                     bus.t_axis_tvalid, bus.t_axis_tdata, bus.hit_idx);
        end
        drain_emit("single");
    endtask

    task automatic test_reset_mid();
        send_ray(32'h7777_0007);
        send_cand(32'h3F800000, 32'h9000_0000, 1'b1, 1'b0);
        send_cand(32'h40000000, 32'h9000_0001, 1'b0, 1'b0);
        areset = 1'b1;
        tick();
        n_checks++;
        if ({bus.cand_tready, bus.obj_axis_tvalid, bus.t_axis_tvalid, bus.ray_axis_tvalid,
             bus.miss_tvalid} !== 5'b0 || bus.hit_idx !== 8'd0 || bus.t_axis_tdata !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_mid_clear: cand_rdy=%b valids=%b idx=%0d t=%h required 0/0000/0/0",
                     bus.cand_tready, {bus.obj_axis_tvalid, bus.t_axis_tvalid, bus.ray_axis_tvalid,
                     bus.miss_tvalid}, bus.hit_idx, bus.t_axis_tdata);
        end
        areset = 1'b0;
        tick();
        n_checks++;
        if (bus.ray_in_tready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_idle: ray_in_tready=%b required 1", bus.ray_in_tready);
        end
        send_ray(32'h8888_0008);
        send_cand(32'h40C00000, 32'h9100_0000, 1'b0, 1'b0);
        send_cand(32'h40E00000, 32'h9100_0001, 1'b1, 1'b1);
        n_checks++;
        if (bus.t_axis_tdata !== 32'h40C00000 || bus.hit_idx !== 8'd0 ||
            bus.obj_axis_tdata !== {6{32'h9100_0000}} || bus.ray_axis_tdata !== {6{32'h8888_0008}}) begin
            n_errors++;
            $display("FAIL reset_mid_fresh: t=%h idx=%0d obj[31:0]=%h required 40c00000/0/91000000",
                     bus.t_axis_tdata, bus.hit_idx, bus.obj_axis_tdata[31:0]);
        end
        drain_emit("reset_mid");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        areset               = 1'b1;
        bus.ray_in_tdata     = '0;
        bus.ray_in_tvalid    = 1'b0;
        bus.cand_tdata       = '0;
        bus.cand_t           = '0;
        bus.cand_is_cylinder = 1'b0;
        bus.cand_tlast       = 1'b0;
        bus.cand_tvalid      = 1'b0;
        bus.obj_axis_tready  = 1'b0;
        bus.t_axis_tready    = 1'b0;
        bus.ray_axis_tready  = 1'b0;
        bus.miss_tready      = 1'b0;

        test_reset();
        test_nearest();
        test_miss();
        test_tie();
        test_inf_subnormal();
        test_backpressure();
        test_single();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
